mux1_core: RTL and testbench

- Clocked 2:1 selector: when `sel`=0, `out` takes input `a`; when `sel`=1, `out` takes input `b`.
- Output is registered, with a valid qualifier.
- A saturating counter records how many times the select value changes between accepted samples.
- Used as a leaf datapath-steering block; the 1-bit default instance replaces bare combinational 2:1 muxes in timing-critical paths.

---
 rtl/mux1_core_if.sv | 23 ++
 rtl/mux1_core.sv | 61 ++++++
 tb/tb_mux1_core.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mux1_core_if.sv
// Steering interface for mux1_core: data/select/valid in, registered selection and toggle count out.
interface mux1_core_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sel;
    logic                 in_valid;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] sel_toggles;

    modport master (
        output a, b, sel, in_valid,
        input  out, out_valid, sel_toggles
    );

    modport slave (
        input  a, b, sel, in_valid,
        output out, out_valid, sel_toggles
    );
endinterface

// File: rtl/mux1_core.sv
// Clocked 2:1 selector with valid qualifier and saturating select-toggle counter.
// Optional MUX1_COMB_OUT_EN: out/out_valid become zero-latency combinational; counter stays registered.
module mux1_core #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mux1_core_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]     w_sel_data;
    logic                 w_toggle;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_last_sel;
    logic                 r_first;

    assign w_sel_data = bus.sel ? bus.b : bus.a;
    assign w_toggle   = !r_first && (bus.sel != r_last_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_last_sel <= 1'b0;
            r_first    <= 1'b1;
        end else if (bus.in_valid) begin
            r_last_sel <= bus.sel;
            r_first    <= 1'b0;
            // Saturate rather than wrap so a long-running count stays meaningful.
            if (w_toggle && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.sel_toggles = r_cnt;

`ifdef MUX1_COMB_OUT_EN
    assign bus.out       = w_sel_data;
    assign bus.out_valid = bus.in_valid;
`else
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out <= w_sel_data;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
`endif
endmodule

// File: tb/tb_mux1_core.sv
// Directed self-checking bench for mux1_core: truth table, gating, toggle count, saturation, wide data.
module tb_mux1_core;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mux1_core_if #(.WIDTH(1),  .CNT_WIDTH(8)) if0 ();
    mux1_core_if #(.WIDTH(1),  .CNT_WIDTH(2)) if1 ();
    mux1_core_if #(.WIDTH(16), .CNT_WIDTH(8)) if2 ();

    mux1_core #(.WIDTH(1),  .CNT_WIDTH(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mux1_core #(.WIDTH(1),  .CNT_WIDTH(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux1_core #(.WIDTH(16), .CNT_WIDTH(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic a, input logic b, input logic sel, input logic v);
        if0.a = a; if0.b = b; if0.sel = sel; if0.in_valid = v;
    endtask

    // Truth table vectors {a,b,sel} with expected out.
    logic [2:0] tt_vec [8];
    logic       tt_exp [8];
    logic       tog_sel [6];
    logic [7:0] tog_exp [6];
    logic [1:0] sat_exp [6];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tt_vec = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
        tt_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tog_sel = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tog_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        if1.a = 1'b0; if1.b = 1'b1; if1.sel = 1'b0; if1.in_valid = 1'b0;
        if2.a = '0;   if2.b = '0;   if2.sel = 1'b0; if2.in_valid = 1'b0;

        // Reset held with active inputs.
        rst_n = 1'b0;
        drv0(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        chk("rst_out",     if0.out,         1'b0);
        chk("rst_valid",   if0.out_valid,   1'b0);
        chk("rst_toggles", if0.sel_toggles, 8'd0);
        drv0(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            drv0(tt_vec[i][2], tt_vec[i][1], tt_vec[i][0], 1'b1);
            cyc();
            chk($sformatf("tt%0d_out", i), if0.out, tt_exp[i]);
            chk($sformatf("tt%0d_vld", i), if0.out_valid, 1'b1);
        end
        chk("tt_toggles", if0.sel_toggles, 8'd1);

        // Drive out to 0, then a non-valid cycle must not update anything.
        drv0(1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("gate_pre_out", if0.out,         1'b0);
        chk("gate_pre_tog", if0.sel_toggles, 8'd2);
        drv0(1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("gate_out",     if0.out,         1'b0);
        chk("gate_valid",   if0.out_valid,   1'b0);
        chk("gate_toggles", if0.sel_toggles, 8'd2);
        // last_sel must still be 0: a valid sel=0 sample adds no toggle.
        drv0(1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("gate_post_out", if0.out,         1'b1);
        chk("gate_post_tog", if0.sel_toggles, 8'd2);

        // Asynchronous reset in the middle of a cycle.
        drv0(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out",     if0.out,         1'b0);
        chk("arst_valid",   if0.out_valid,   1'b0);
        chk("arst_toggles", if0.sel_toggles, 8'd0);
        #1;
        rst_n = 1'b1;
        cyc();

        // Toggle sequence 0,0,1,1,0,1.
        for (int i = 0; i < 6; i++) begin
            drv0(1'b0, 1'b1, tog_sel[i], 1'b1);
            cyc();
            chk($sformatf("tog%0d", i), if0.sel_toggles, tog_exp[i]);
        end
        drv0(1'b0, 1'b0, 1'b0, 1'b0);

        // First sample after reset with sel=1 never counts.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
        drv0(1'b0, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("first_out",     if0.out,         1'b1);
        chk("first_toggles", if0.sel_toggles, 8'd0);
        drv0(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation with a 2-bit counter.
        for (int i = 0; i < 6; i++) begin
            if1.sel = i[0];
            if1.in_valid = 1'b1;
            cyc();
            chk($sformatf("sat%0d", i), if1.sel_toggles, sat_exp[i]);
            chk($sformatf("sat%0d_out", i), if1.out, i[0]);
        end
        if1.in_valid = 1'b0;

        // Wide data.
        if2.a = 16'hA5A5;
        if2.b = 16'h5A5A;
        if2.in_valid = 1'b1;
        if2.sel = 1'b0;
`ifdef MUX1_COMB_OUT_EN
        #1;
        chk("wide_sel0", if2.out, 16'hA5A5);
        if2.sel = 1'b1;
        #1;
        chk("wide_sel1", if2.out, 16'h5A5A);
        chk("wide_vld",  if2.out_valid, 1'b1);
`else
        cyc();
        chk("wide_sel0", if2.out, 16'hA5A5);
        if2.sel = 1'b1;
        #1;
        chk("wide_hold", if2.out, 16'hA5A5);
        cyc();
        chk("wide_sel1", if2.out, 16'h5A5A);
        chk("wide_vld",  if2.out_valid, 1'b1);
`endif
        if2.in_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
